// File: rtl/reflet_irq_conditioner_pkg.sv
// Shared constants for the external interrupt conditioner and its per-line slice.
package reflet_irq_conditioner_pkg;

    localparam int INT_LINES = 4;

    // "No line selected" code, matching the controller's normal-context level.
    localparam logic [2:0] INT_PRIO_NONE = 3'd4;

    function automatic int cnt_width(input int debounce);
        return $clog2(debounce) + 1;
    endfunction

    // Index of the lowest set bit, i.e. the highest-priority request.
    function automatic logic [2:0] lowest_set(input logic [INT_LINES-1:0] v);
        logic [2:0] idx;
        idx = INT_PRIO_NONE;
        for (int i = INT_LINES - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/reflet_irq_line.sv
// One interrupt line: synchroniser, debounce filter, rising-edge detect,
// pending latch and sticky overflow flag.
module reflet_irq_line
    import reflet_irq_conditioner_pkg::*;
#(
    parameter int sync_stages = 2,
    parameter int debounce    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic edge_mode,
    input  logic clr,
    input  logic ovf_clr,
    output logic filt,
    output logic pending,
    output logic overflow
);

    localparam int            CW       = cnt_width(debounce);
    localparam logic [CW-1:0] CNT_LAST = CW'(debounce - 1);

    logic [sync_stages-1:0] sync;
    logic                   s;
    logic                   filt_d;
    logic                   rise;
    logic                   ovf_set;
    logic [CW-1:0]          cnt;

    assign s       = sync[sync_stages-1];
    assign rise    = filt & ~filt_d;
    assign ovf_set = edge_mode & rise & pending & ~clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[sync_stages-2:0], irq};
        end
    end

    // The counter tracks how long s has disagreed with filt; any agreement restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (s == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= s;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_d <= 1'b0;
        end else begin
            filt_d <= filt;
        end
    end

    // A rise wins over a same-cycle service so a back-to-back event is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if (!edge_mode) begin
            pending <= 1'b0;
        end else if (rise) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/reflet_irq_conditioner.sv
// Conditions raw external interrupt lines for reflet_interrupt: works out which
// line the CPU is servicing and muxes level or latched-edge requests out.
module reflet_irq_conditioner
    import reflet_irq_conditioner_pkg::*;
#(
    parameter int sync_stages = 2,
    parameter int debounce    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INT_LINES-1:0] irq_in,
    input  logic [INT_LINES-1:0] edge_sel,
    input  logic [INT_LINES-1:0] int_mask,
    input  logic                 int_taken,
    input  logic [INT_LINES-1:0] ovf_clr,
    output logic [INT_LINES-1:0] ext_int,
    output logic [INT_LINES-1:0] overflow
);

    logic [INT_LINES-1:0] filt;
    logic [INT_LINES-1:0] pending;
    logic [INT_LINES-1:0] clr;
    logic [2:0]           sel;

    assign ext_int = (edge_sel & pending) | (~edge_sel & filt);

    // Same priority order as the controller, so clr hits the line it entered.
    always_comb begin
        sel = lowest_set(ext_int & int_mask);
        clr = '0;
        for (int i = 0; i < INT_LINES; i++) begin
            clr[i] = int_taken & (sel == 3'(i)) & edge_sel[i];
        end
    end

    for (genvar i = 0; i < INT_LINES; i++) begin : g_line
        reflet_irq_line #(
            .sync_stages(sync_stages),
            .debounce   (debounce)
        ) u_line (
            .clk      (clk),
            .reset    (reset),
            .irq      (irq_in[i]),
            .edge_mode(edge_sel[i]),
            .clr      (clr[i]),
            .ovf_clr  (ovf_clr[i]),
            .filt     (filt[i]),
            .pending  (pending[i]),
            .overflow (overflow[i])
        );
    end

endmodule

// File: tb/tb_reflet_irq_conditioner.sv
// Bench for reflet_irq_conditioner: a debounce=1 and a debounce=4 instance share
// stimulus and are both compared every cycle against a window-based model.
module tb_reflet_irq_conditioner;

    localparam int SYNC  = 2;
    localparam int DEB_A = 1;
    localparam int DEB_B = 4;
    localparam int HIST  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in    = 4'b0;
    logic [3:0] edge_sel  = 4'b0;
    logic [3:0] int_mask  = 4'b0;
    logic       int_taken = 1'b0;
    logic [3:0] ovf_clr   = 4'b0;
    logic [3:0] ext_int_a, overflow_a, ext_int_b, overflow_b;

    int vectors     = 0;
    int miscompares = 0;

    // Model state, index 0 = debounce 1 instance, 1 = debounce 4 instance.
    logic [HIST-1:0] m_raw [2][4];
    logic [3:0]      m_filt  [2] = '{4'b0, 4'b0};
    logic [3:0]      m_filtd [2] = '{4'b0, 4'b0};
    logic [3:0]      m_pend  [2] = '{4'b0, 4'b0};
    logic [3:0]      m_ovf   [2] = '{4'b0, 4'b0};

    reflet_irq_conditioner #(.sync_stages(SYNC), .debounce(DEB_A)) u_dut_a (
        .clk(clk), .reset(reset), .irq_in(irq_in), .edge_sel(edge_sel),
        .int_mask(int_mask), .int_taken(int_taken), .ovf_clr(ovf_clr),
        .ext_int(ext_int_a), .overflow(overflow_a)
    );

    reflet_irq_conditioner #(.sync_stages(SYNC), .debounce(DEB_B)) u_dut_b (
        .clk(clk), .reset(reset), .irq_in(irq_in), .edge_sel(edge_sel),
        .int_mask(int_mask), .int_taken(int_taken), .ovf_clr(ovf_clr),
        .ext_int(ext_int_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] m_ext(input int d);
        return (edge_sel & m_pend[d]) | (~edge_sel & m_filt[d]);
    endfunction

    // filt follows the raw input SYNC edges late, once the last deb samples agree.
    task automatic model_step(input int d, input int deb);
        logic [3:0] ext, clrv, rise, nfilt;
        logic       found, all1, all0;
        ext   = m_ext(d);
        clrv  = 4'b0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && ext[i] && int_mask[i]) begin
                found   = 1'b1;
                clrv[i] = int_taken & edge_sel[i];
            end
        end
        rise  = m_filt[d] & ~m_filtd[d];
        nfilt = m_filt[d];
        for (int i = 0; i < 4; i++) begin
            m_raw[d][i] = {m_raw[d][i][HIST-2:0], irq_in[i]};
            all1 = 1'b1;
            all0 = 1'b1;
            for (int k = 0; k < deb; k++) begin
                if (m_raw[d][i][SYNC+k]) all0 = 1'b0;
                else                     all1 = 1'b0;
            end
            if (all1) nfilt[i] = 1'b1;
            if (all0) nfilt[i] = 1'b0;
            if (edge_sel[i] && rise[i] && m_pend[d][i] && !clrv[i]) m_ovf[d][i] = 1'b1;
            else if (ovf_clr[i])                                    m_ovf[d][i] = 1'b0;
            if (!edge_sel[i])  m_pend[d][i] = 1'b0;
            else if (rise[i])  m_pend[d][i] = 1'b1;
            else if (clrv[i])  m_pend[d][i] = 1'b0;
        end
        m_filtd[d] = m_filt[d];
        m_filt[d]  = nfilt;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_filt[d]  = 4'b0;
                m_filtd[d] = 4'b0;
                m_pend[d]  = 4'b0;
                m_ovf[d]   = 4'b0;
                for (int i = 0; i < 4; i++) m_raw[d][i] = '0;
            end
        end else begin
            model_step(0, DEB_A);
            model_step(1, DEB_B);
        end
    end

    always @(posedge clk) begin
        #1;
        check_output("ext_int_a", ext_int_a, m_ext(0));
        check_output("overflow_a", overflow_a, m_ovf[0]);
        check_output("ext_int_b", ext_int_b, m_ext(1));
        check_output("overflow_b", overflow_b, m_ovf[1]);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic service(input logic [3:0] mask);
        int_mask  = mask;
        int_taken = 1'b1;
        tick(1);
        int_taken = 1'b0;
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(5) == 0) irq_in[i] = ~irq_in[i];
            end
            if ($urandom_range(49) == 0) edge_sel = 4'($urandom);
            int_mask  = 4'($urandom);
            int_taken = ($urandom_range(3) == 0);
            ovf_clr   = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        tick(3);
        check_output("reset ext_int_a", ext_int_a, 4'b0);
        check_output("reset overflow_a", overflow_a, 4'b0);
        check_output("reset ext_int_b", ext_int_b, 4'b0);
        reset = 1'b1;
        tick(4);

        // Edge line 0, one-cycle pulse: pending three edges later.
        edge_sel  = 4'b0001;
        irq_in[0] = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            check_output("edge0 latency a", {3'b0, ext_int_a[0]}, {3'b0, (t >= 4)});
            check_output("edge0 glitch b", {3'b0, ext_int_b[0]}, 4'b0);
            if (t == 1) irq_in[0] = 1'b0;
        end
        service(4'hF);
        check_output("edge0 serviced", {3'b0, ext_int_a[0]}, 4'b0);
        check_output("edge0 no overflow", overflow_a, 4'b0);
        tick(6);

        // Level line 2 held for 20 edges; service pulses do not touch it.
        edge_sel  = 4'b0000;
        int_mask  = 4'hF;
        irq_in[2] = 1'b1;
        for (int t = 1; t <= 28; t++) begin
            @(negedge clk);
            check_output("level2 a", {3'b0, ext_int_a[2]}, {3'b0, (t >= 3 && t <= 22)});
            check_output("level2 b", {3'b0, ext_int_b[2]}, {3'b0, (t >= 6 && t <= 25)});
            if (t == 20) irq_in[2] = 1'b0;
            int_taken = (t == 8 || t == 12);
        end
        int_taken = 1'b0;
        tick(4);

        // Debounce: a 3-cycle pulse is rejected by b, a 4-cycle pulse gets through.
        irq_in[1] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            check_output("deb3 a", {3'b0, ext_int_a[1]}, {3'b0, (t >= 3 && t <= 5)});
            check_output("deb3 b", {3'b0, ext_int_b[1]}, 4'b0);
            if (t == 3) irq_in[1] = 1'b0;
        end
        irq_in[1] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            check_output("deb4 a", {3'b0, ext_int_a[1]}, {3'b0, (t >= 3 && t <= 6)});
            check_output("deb4 b", {3'b0, ext_int_b[1]}, {3'b0, (t >= 6 && t <= 9)});
            if (t == 4) irq_in[1] = 1'b0;
        end
        tick(4);

        // Priority of servicing between pending lines 1 and 3.
        edge_sel = 4'hF;
        irq_in   = 4'b1010;
        tick(1);
        irq_in = 4'b0;
        tick(3);
        check_output("prio both pending", ext_int_a, 4'b1010);
        service(4'hF);
        check_output("prio first clears 1", ext_int_a, 4'b1000);
        service(4'hF);
        check_output("prio second clears 3", ext_int_a, 4'b0000);
        tick(3);
        irq_in = 4'b1010;
        tick(1);
        irq_in = 4'b0;
        tick(3);
        service(4'b1000);
        check_output("prio masked clears 3", ext_int_a, 4'b0010);
        service(4'hF);
        tick(3);

        // Overflow on line 0, then a rise landing on the service edge.
        irq_in[0] = 1'b1;
        tick(1);
        irq_in[0] = 1'b0;
        tick(4);
        irq_in[0] = 1'b1;
        tick(1);
        irq_in[0] = 1'b0;
        tick(3);
        check_output("ovf set", overflow_a, 4'b0001);
        check_output("ovf still pending", ext_int_a, 4'b0001);
        tick(5);
        check_output("ovf sticky", overflow_a, 4'b0001);
        ovf_clr = 4'b0001;
        tick(1);
        ovf_clr = 4'b0;
        check_output("ovf cleared", overflow_a, 4'b0000);
        irq_in[0] = 1'b1;
        tick(1);
        irq_in[0] = 1'b0;
        tick(2);
        service(4'hF);
        check_output("rise on clr keeps pending", ext_int_a, 4'b0001);
        check_output("rise on clr no ovf", overflow_a, 4'b0000);
        service(4'hF);
        check_output("rise on clr single event", ext_int_a, 4'b0000);
        tick(4);

        // Asynchronous reset mid-cycle with line 2 pending and overflow set.
        irq_in = 4'b0101;
        tick(1);
        irq_in = 4'b0100;
        tick(4);
        irq_in = 4'b0101;
        tick(1);
        irq_in = 4'b0100;
        tick(4);
        check_output("pre-reset ext", ext_int_a, 4'b0101);
        check_output("pre-reset ovf", overflow_a, 4'b0001);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_output("async reset ext_a", ext_int_a, 4'b0);
        check_output("async reset ovf_a", overflow_a, 4'b0);
        check_output("async reset ext_b", ext_int_b, 4'b0);
        tick(2);
        reset = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            check_output("post-reset edge2", ext_int_a, (t >= 4) ? 4'b0100 : 4'b0000);
        end
        service(4'hF);
        check_output("post-reset serviced", ext_int_a, 4'b0000);
        tick(5);
        check_output("post-reset one event", ext_int_a, 4'b0000);

        apply_stimulus(800);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reflet_irq_conditioner.md
Name: reflet_irq_conditioner

Overview:
Conditions the raw, asynchronous external interrupt lines before they reach the CPU's interrupt controller: per-line synchronisation, debounce filtering, and either level pass-through or rising-edge capture into a pending latch. Edge-captured lines stay pending until the CPU actually enters the matching routine, so short pulses are never lost. Sits directly upstream of reflet_interrupt: drives its ext_int[3:0] and consumes its int output.

Parameters:
sync_stages, 2, number of synchroniser flops per line (minimum 2)
debounce, 1, consecutive identical synchronised samples required before the filtered value changes (minimum 1; 1 = no filtering)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
irq_in  input  4  raw external interrupt requests, asynchronous to clk; irq_in[0] is line 0 (highest priority)
edge_sel  input  4  per line: 1 = rising-edge captured, 0 = level pass-through
int_mask  input  4  same mask the CPU applies; used only to identify the serviced line
int_taken  input  1  connected to the interrupt controller's int output; high for one cycle when an interrupt is entered
ovf_clr  input  4  per line: clears the sticky overflow flag
ext_int  output  4  conditioned requests to the interrupt controller
overflow  output  4  sticky: a new edge arrived while the line was already pending

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on port reset. While reset = 0: all synchroniser flops, filtered values, delayed filtered values, debounce counters, pending bits and overflow bits = 0; ext_int = 0; overflow = 0.
- Synchroniser: sync_stages-deep shift register per line; s = last stage.
- Debounce: one counter per line, width clog2(debounce)+1.
  - If s == filt: counter <= 0.
  - Else if counter == debounce-1: filt <= s, counter <= 0.
  - Else: counter++.
  - A glitch shorter than debounce cycles leaves filt unchanged.
- Edge detect: filt_d <= filt every cycle; rise = filt & ~filt_d.
- Serviced line: sel = lowest index i with ext_int[i] & int_mask[i]. clr[i] = int_taken & (i == sel) & edge_sel[i]. Matches the controller's priority order.
- Pending, per edge line, in priority order:
  - rise and pending and !clr: overflow[i] <= 1, pending stays 1.
  - rise: pending <= 1. A rise in the same cycle as clr keeps pending = 1 and is not an overflow.
  - clr: pending <= 0.
- ext_int[i] = edge_sel[i] ? pending[i] : filt[i].
- int_taken never affects level lines.
- When edge_sel[i] is 0, pending[i] is forced to 0 every cycle. Switching a line to edge mode never fabricates an edge by itself; only rise sets pending.
- Overflow: set has priority over ovf_clr in the same cycle.
- Latency, irq_in[i] high set up before clk edge N, no glitch:
  - filt high after edge N+sync_stages-1+debounce.
  - Level line: ext_int high at that same edge.
  - Edge line: ext_int high one edge later.
  - Defaults: level = N+2, edge = N+3.
  - Deassertion is symmetric for filt.
- After reset release, a line held high produces one rise, because filt_d starts at 0. This is intended.
- Reset mid-operation clears pending interrupts; no event survives reset.

Decomposition:
- Shared header reflet.vh: add `int_lines (4) and `int_prio_none (3'd4, matching the controller's "normal context" level). No new typedefs.
- One sub-module, reflet_irq_line: per-line synchroniser, debounce, edge detect, pending and overflow. Instantiated 4x.
- The top level holds only the priority select for clr and the output muxing.

Test Plan:
- Defaults, edge_sel=4'b0001, 1-cycle pulse on irq_in[0] before edge 10 -> ext_int[0] rises after edge 13 and holds; int_taken pulse with int_mask=4'hF -> ext_int[0]=0 the next cycle; overflow=0.
- edge_sel=4'b0000, irq_in[2] high for 20 cycles -> ext_int[2] follows with 2-cycle delay on both edges; int_taken pulses leave ext_int[2]=1.
- debounce=4, edge_sel=0: 3-cycle pulse on irq_in[1] -> ext_int[1] never asserts; 4-cycle pulse -> ext_int[1] high for 4 cycles, starting edge N+5.
- edge_sel=4'hF, lines 1 and 3 pending, int_mask=4'hF, one int_taken -> only ext_int[1] clears; second int_taken -> ext_int[3] clears; with int_mask=4'b1000 the first int_taken clears line 3.
- Edge line 0 pending, second pulse before service -> overflow[0]=1 and sticky; ovf_clr[0] -> 0 next cycle. A rise coinciding with clr -> pending stays 1, overflow stays 0.
- Line 2 pending, assert reset asynchronously mid-cycle -> ext_int and overflow = 0 immediately; after release with irq_in[2] held high, one new pending event appears at the default edge latency.
